// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM
// states and the datapath mux/ALU select codes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PC_ALU      = 2'd0,
        PC_ALUOUT   = 2'd1,
        PC_ALU_JALR = 2'd2
    } pcsrc_e;

    typedef enum logic [1:0] {
        A_PC    = 2'd0,
        A_OLDPC = 2'd1,
        A_RS1   = 2'd2,
        A_ZERO  = 2'd3
    } asrc_e;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_FOUR = 2'd1,
        B_IMM  = 2'd2
    } bsrc_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'd0,
        ALU_BRANCH = 2'd1,
        ALU_FUNCT  = 2'd2
    } aluop_e;

    typedef enum logic [1:0] {
        WB_ALUOUT = 2'd0,
        WB_MDR    = 2'd1,
        WB_PC     = 2'd2
    } wbsel_e;

    // True for every opcode this core executes; anything else faults.
    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle. master = control FSM,
// slave = datapath side that owns IR, ALU flags and the memory port.
interface multicycle_controller_if;
    logic [6:0] Opcode;
    logic [2:0] Funct3;
    logic       BrTaken;
    logic       MemReady;
    logic       MemReq;
    logic       MemWrite;
    logic       IorD;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] PCSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       RegWrite;
    logic [1:0] WBSel;
    logic       Retire;
    logic       Fault;
    logic [2:0] State;

    // Funct3 goes straight from IR to the ALU decoder; the FSM never sees it.
    modport master (
        input  Opcode, BrTaken, MemReady,
        output MemReq, MemWrite, IorD, IRWrite, PCWrite, PCSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegWrite, WBSel, Retire, Fault, State
    );

    modport slave (
        output Opcode, Funct3, BrTaken, MemReady,
        input  MemReq, MemWrite, IorD, IRWrite, PCWrite, PCSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegWrite, WBSel, Retire, Fault, State
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles of an outstanding memory request and flags a bus
// timeout on the last allowed cycle if memory still has not answered.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic busy,
    output logic timeout
);
    localparam int             CW   = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0]  LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: restart on clear, otherwise advance while stalled, saturating.
    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (busy && cnt_q != LAST)
            cnt_d = cnt_q + CW'(1);
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // clear covers MemReady, so a completing final cycle never times out.
    assign timeout = busy & ~clear & (cnt_q == LAST);
endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core. One instruction at a time,
// one shared memory port; outputs decode from state/Opcode, with MemReady
// and BrTaken gating the few enables that depend on them.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);
    state_e state_q;
    logic   fault_q;
    logic   timeout;
    logic   tmr_clear;

    logic   req, iord, mwr, irw, pcw, rw, ret;
    pcsrc_e pcsrc;
    asrc_e  asrc;
    bsrc_e  bsrc;
    aluop_e aluop;
    wbsel_e wbsel;

    logic   is_load, is_store;
    assign is_load  = (bus.Opcode == OP_LOAD);
    assign is_store = (bus.Opcode == OP_STORE);

    // Counter sits at zero outside a request, so every FETCH/MEM starts fresh.
    assign tmr_clear = bus.MemReady | ~req;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .busy    (req),
        .timeout (timeout)
    );

    // State sequencing and sticky fault flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (bus.MemReady)  state_q <= ST_DECODE;
                    else if (timeout) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (is_legal(bus.Opcode)) state_q <= ST_EXEC;
                    else begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    case (bus.Opcode)
                        OP_R, OP_I, OP_LUI:          state_q <= ST_WB;
                        OP_LOAD, OP_STORE:           state_q <= ST_MEM;
                        OP_BRANCH, OP_JAL, OP_JALR:  state_q <= ST_FETCH;
                        default: begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (bus.MemReady)  state_q <= is_load ? ST_WB : ST_FETCH;
                    else if (timeout) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end
                end
                ST_WB:    state_q <= ST_FETCH;
                ST_FAULT: fault_q <= 1'b1;
                default: begin
                    state_q <= ST_FAULT;
                    fault_q <= 1'b1;
                end
            endcase
        end
    end

    // Control decode for the current state; everything idles unless named.
    always_comb begin
        req   = 1'b0;
        iord  = 1'b0;
        mwr   = 1'b0;
        irw   = 1'b0;
        pcw   = 1'b0;
        rw    = 1'b0;
        ret   = 1'b0;
        pcsrc = PC_ALU;
        asrc  = A_PC;
        bsrc  = B_RS2;
        aluop = ALU_ADD;
        wbsel = WB_ALUOUT;
        case (state_q)
            ST_FETCH: begin
                req   = 1'b1;
                asrc  = A_PC;
                bsrc  = B_FOUR;
                aluop = ALU_ADD;
                irw   = bus.MemReady;
                pcw   = bus.MemReady;
                pcsrc = PC_ALU;
            end
            ST_DECODE: begin
                // Branch/JAL target OldPC+Imm lands in ALUOut.
                asrc  = A_OLDPC;
                bsrc  = B_IMM;
                aluop = ALU_ADD;
            end
            ST_EXEC: begin
                case (bus.Opcode)
                    OP_R: begin
                        asrc = A_RS1; bsrc = B_RS2; aluop = ALU_FUNCT;
                    end
                    OP_I: begin
                        asrc = A_RS1; bsrc = B_IMM; aluop = ALU_FUNCT;
                    end
                    OP_LOAD, OP_STORE: begin
                        asrc = A_RS1; bsrc = B_IMM; aluop = ALU_ADD;
                    end
                    OP_BRANCH: begin
                        asrc  = A_RS1; bsrc = B_RS2; aluop = ALU_BRANCH;
                        pcw   = bus.BrTaken;
                        pcsrc = PC_ALUOUT;
                        ret   = 1'b1;
                    end
                    OP_JAL: begin
                        // PC still holds old+4 this cycle, so the link value is correct.
                        pcw   = 1'b1; pcsrc = PC_ALUOUT;
                        rw    = 1'b1; wbsel = WB_PC;
                        ret   = 1'b1;
                    end
                    OP_JALR: begin
                        asrc  = A_RS1; bsrc = B_IMM; aluop = ALU_ADD;
                        pcw   = 1'b1; pcsrc = PC_ALU_JALR;
                        rw    = 1'b1; wbsel = WB_PC;
                        ret   = 1'b1;
                    end
                    OP_LUI: begin
                        asrc = A_ZERO; bsrc = B_IMM; aluop = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                req  = 1'b1;
                iord = 1'b1;
                mwr  = is_store;
                ret  = is_store & bus.MemReady;
            end
            ST_WB: begin
                rw    = 1'b1;
                wbsel = is_load ? WB_MDR : WB_ALUOUT;
                ret   = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset blanks every control output immediately, not just after the edge.
    assign bus.MemReq   = rst_n & req;
    assign bus.MemWrite = rst_n & mwr;
    assign bus.IorD     = rst_n & iord;
    assign bus.IRWrite  = rst_n & irw;
    assign bus.PCWrite  = rst_n & pcw;
    assign bus.RegWrite = rst_n & rw;
    assign bus.Retire   = rst_n & ret;
    assign bus.Fault    = rst_n & fault_q;
    assign bus.PCSrc    = rst_n ? 2'(pcsrc) : 2'b00;
    assign bus.ALUSrcA  = rst_n ? 2'(asrc)  : 2'b00;
    assign bus.ALUSrcB  = rst_n ? 2'(bsrc)  : 2'b00;
    assign bus.ALUOp    = rst_n ? 2'(aluop) : 2'b00;
    assign bus.WBSel    = rst_n ? 2'(wbsel) : 2'b00;
    assign bus.State    = rst_n ? 3'(state_q) : 3'b000;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed per-cycle vector table, hand
// sequences for timeout corners, then random instructions with random
// memory waits checked against latency/count rules.
module tb_multicycle_controller;

    localparam logic [6:0] OR_ = 7'h33, OI = 7'h13, OL = 7'h03, OS = 7'h23;
    localparam logic [6:0] OB  = 7'h63, OJ = 7'h6F, OJR = 7'h67, OU = 7'h37;
    localparam logic [6:0] OX  = 7'h7F;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_controller_if bus();

    multicycle_controller #(.MEM_TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic       br;
        logic       rdy;
        logic       m;      // check ALU operand/op selects
        logic [2:0] st;
        logic [4:0] en;     // {MemReq, IorD, MemWrite, IRWrite, PCWrite}
        logic [1:0] pcsrc, asrc, bsrc, aluop;
        logic       rw;
        logic [1:0] wb;
        logic       ret, flt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic rst, input logic [6:0] op, input logic br,
                               input logic rdy, input logic m, input logic [2:0] st,
                               input logic [4:0] en, input logic [1:0] pcsrc,
                               input logic [1:0] asrc, input logic [1:0] bsrc,
                               input logic [1:0] aluop, input logic rw,
                               input logic [1:0] wb, input logic ret, input logic flt);
        vec_t r;
        r.rst = rst; r.op = op; r.br = br; r.rdy = rdy; r.m = m; r.st = st; r.en = en;
        r.pcsrc = pcsrc; r.asrc = asrc; r.bsrc = bsrc; r.aluop = aluop;
        r.rw = rw; r.wb = wb; r.ret = ret; r.flt = flt;
        return r;
    endfunction

    // FETCH cycle: PC+4 via ALU, IR/PC load only on the ready cycle.
    function automatic vec_t F(input logic [6:0] op, input logic rdy);
        return v(1, op, 0, rdy, 1, 3'd0, rdy ? 5'b10011 : 5'b10000, 2'd0, 2'd0, 2'd1, 2'd0, 0, 2'd0, 0, 0);
    endfunction

    // DECODE cycle: OldPC + Imm; MemReady noise here must be ignored.
    function automatic vec_t D(input logic [6:0] op);
        return v(1, op, 0, 1, 1, 3'd1, 5'b00000, 2'd0, 2'd1, 2'd2, 2'd0, 0, 2'd0, 0, 0);
    endfunction

    function automatic vec_t R0();
        return v(0, OI, 0, 1, 1, 3'd0, 5'b00000, 2'd0, 2'd0, 2'd0, 2'd0, 0, 2'd0, 0, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic apply_row(input int idx, input vec_t r);
        logic [20:0] got, exp, msk;
        logic        fr;
        rst_n        = r.rst;
        bus.Opcode   = r.op;
        bus.BrTaken  = r.br;
        bus.MemReady = r.rdy;
        #1;
        fr  = ~r.rst;
        got = {bus.State, bus.MemReq, bus.IorD, bus.MemWrite, bus.IRWrite, bus.PCWrite,
               bus.PCSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.RegWrite, bus.WBSel,
               bus.Retire, bus.Fault};
        exp = {r.st, r.en, r.pcsrc, r.asrc, r.bsrc, r.aluop, r.rw, r.wb, r.ret, r.flt};
        msk = {3'b111, 1'b1, r.en[4] | fr, 3'b111, {2{r.en[0] | fr}},
               {6{r.m | fr}}, 1'b1, {2{r.rw | fr}}, 2'b11};
        n_tests++;
        if ((got & msk) !== (exp & msk)) begin
            n_fail++;
            $display("FAIL row%0d got=%h exp=%h mask=%h", idx, got, exp, msk);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.MemReady = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        bus.MemReady = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [6:0] ops [8];
        logic [6:0] op;
        logic       br, flt_seen;
        int         waits [2];
        int         bad, rc, cls, wf, wm, idx, cnt;
        int         c_pcw, c_rw, c_req, c_mwr, c_irw;
        int         e_rc, e_pcw, e_rw, e_req, e_mwr;
        bit         ldst;

        ops = '{OR_, OI, OL, OS, OB, OJ, OJR, OU};
        rst_n = 1'b0;
        bus.Opcode = OI; bus.Funct3 = 3'b000; bus.BrTaken = 1'b0; bus.MemReady = 1'b1;

        // ---- directed per-cycle table ----
        tbl.push_back(R0()); tbl.push_back(R0());
        tbl.push_back(F(OI, 0));                               // MemReq right after release
        // ADDI
        tbl.push_back(F(OI, 1)); tbl.push_back(D(OI));
        tbl.push_back(v(1, OI, 0, 0, 1, 3'd2, 5'b00000, 2'd0, 2'd2, 2'd2, 2'd2, 0, 2'd0, 0, 0));
        tbl.push_back(v(1, OI, 0, 1, 0, 3'd4, 5'b00000, 2'd0, 2'd0, 2'd0, 2'd0, 1, 2'd0, 1, 0));
        // LW with three wait cycles in MEM, retires in cycle 8
        tbl.push_back(F(OL, 1)); tbl.push_back(D(OL));
        tbl.push_back(v(1, OL, 0, 0, 1, 3'd2, 5'b00000, 2'd0, 2'd2, 2'd2, 2'd0, 0, 2'd0, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(1, OL, 0, 0, 0, 3'd3, 5'b11000, 2'd0, 2'd0, 2'd0, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(v(1, OL, 0, 1, 0, 3'd3, 5'b11000, 2'd0, 2'd0, 2'd0, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(v(1, OL, 0, 0, 0, 3'd4, 5'b00000, 2'd0, 2'd0, 2'd0, 2'd0, 1, 2'd1, 1, 0));
        // BEQ taken / not taken
        tbl.push_back(F(OB, 1)); tbl.push_back(D(OB));
        tbl.push_back(v(1, OB, 1, 0, 1, 3'd2, 5'b00001, 2'd1, 2'd2, 2'd0, 2'd1, 0, 2'd0, 1, 0));
        tbl.push_back(F(OB, 1)); tbl.push_back(D(OB));
        tbl.push_back(v(1, OB, 0, 0, 1, 3'd2, 5'b00000, 2'd0, 2'd2, 2'd0, 2'd1, 0, 2'd0, 1, 0));
        // SW zero wait
        tbl.push_back(F(OS, 1)); tbl.push_back(D(OS));
        tbl.push_back(v(1, OS, 0, 0, 1, 3'd2, 5'b00000, 2'd0, 2'd2, 2'd2, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(v(1, OS, 0, 1, 0, 3'd3, 5'b11100, 2'd0, 2'd0, 2'd0, 2'd0, 0, 2'd0, 1, 0));
        // JAL, JALR
        tbl.push_back(F(OJ, 1)); tbl.push_back(D(OJ));
        tbl.push_back(v(1, OJ, 0, 0, 0, 3'd2, 5'b00001, 2'd1, 2'd0, 2'd0, 2'd0, 1, 2'd2, 1, 0));
        tbl.push_back(F(OJR, 1)); tbl.push_back(D(OJR));
        tbl.push_back(v(1, OJR, 0, 0, 1, 3'd2, 5'b00001, 2'd2, 2'd2, 2'd2, 2'd0, 1, 2'd2, 1, 0));
        // LUI, R-type
        tbl.push_back(F(OU, 1)); tbl.push_back(D(OU));
        tbl.push_back(v(1, OU, 0, 0, 1, 3'd2, 5'b00000, 2'd0, 2'd3, 2'd2, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(v(1, OU, 0, 0, 0, 3'd4, 5'b00000, 2'd0, 2'd0, 2'd0, 2'd0, 1, 2'd0, 1, 0));
        tbl.push_back(F(OR_, 1)); tbl.push_back(D(OR_));
        tbl.push_back(v(1, OR_, 0, 0, 1, 3'd2, 5'b00000, 2'd0, 2'd2, 2'd0, 2'd2, 0, 2'd0, 0, 0));
        tbl.push_back(v(1, OR_, 0, 0, 0, 3'd4, 5'b00000, 2'd0, 2'd0, 2'd0, 2'd0, 1, 2'd0, 1, 0));
        // Store interrupted by reset mid-MEM
        tbl.push_back(F(OS, 1)); tbl.push_back(D(OS));
        tbl.push_back(v(1, OS, 0, 0, 1, 3'd2, 5'b00000, 2'd0, 2'd2, 2'd2, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(v(1, OS, 0, 0, 0, 3'd3, 5'b11100, 2'd0, 2'd0, 2'd0, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(R0());
        tbl.push_back(F(OS, 0));
        // Illegal opcode -> FAULT, sticky until reset
        tbl.push_back(F(OX, 1)); tbl.push_back(D(OX));
        for (int i = 0; i < 2; i++)
            tbl.push_back(v(1, OX, 1, 1, 0, 3'd5, 5'b00000, 2'd0, 2'd0, 2'd0, 2'd0, 0, 2'd0, 0, 1));
        tbl.push_back(R0());
        tbl.push_back(F(OI, 0));

        @(negedge clk);
        foreach (tbl[i]) apply_row(i, tbl[i]);

        // ---- timeout: MemReady stuck low through FETCH ----
        bus.Opcode = OI;
        do_reset();
        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            bus.MemReady = 1'b0;
            #1;
            if (!(bus.MemReq === 1'b1 && bus.State === 3'd0 && bus.Fault === 1'b0)) bad++;
            @(negedge clk);
        end
        chk("tmo_hold16", bad, 0);
        #1;
        chk("tmo_fault", {bus.State, bus.Fault, bus.MemReq}, {3'd5, 1'b1, 1'b0});
        @(negedge clk);

        // ---- MemReady on the final allowed cycle beats the timeout ----
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            bus.MemReady = 1'b0;
            @(negedge clk);
        end
        bus.MemReady = 1'b1;
        #1;
        chk("tmo_last_irw", {bus.MemReq, bus.IRWrite}, 2'b11);
        @(negedge clk);
        bus.MemReady = 1'b0;
        #1;
        chk("tmo_last_decode", {bus.State, bus.Fault}, {3'd1, 1'b0});
        @(negedge clk);

        // ---- random instructions against latency/count rules ----
        do_reset();
        for (int n = 0; n < 40; n++) begin
            cls = $urandom_range(0, 7);
            op  = ops[cls];
            br  = 1'($urandom_range(0, 1));
            wf  = $urandom_range(0, 4);
            wm  = $urandom_range(0, 4);
            waits[0] = wf; waits[1] = wm;
            idx = 0; cnt = 0; rc = 0; flt_seen = 1'b0;
            c_pcw = 0; c_rw = 0; c_req = 0; c_mwr = 0; c_irw = 0;
            for (int c = 1; c <= 40 && rc == 0; c++) begin
                bus.Opcode  = op;
                bus.BrTaken = br;
                if (bus.MemReq === 1'b1)
                    bus.MemReady = (cnt >= ((idx < 2) ? waits[idx] : 0));
                else
                    bus.MemReady = 1'($urandom_range(0, 1));
                #1;
                if (bus.MemReq === 1'b1) begin
                    c_req++;
                    if (bus.MemReady) begin idx++; cnt = 0; end
                    else cnt++;
                end
                c_pcw += int'(bus.PCWrite);
                c_rw  += int'(bus.RegWrite);
                c_mwr += int'(bus.MemWrite);
                c_irw += int'(bus.IRWrite);
                flt_seen |= bus.Fault;
                if (bus.Retire === 1'b1) rc = c;
                @(negedge clk);
            end
            ldst  = (op == OL) || (op == OS);
            e_rc  = ((op == OB) || (op == OJ) || (op == OJR)) ? 3 : (op == OL) ? 5 : 4;
            e_rc += wf + (ldst ? wm : 0);
            e_pcw = 1 + ((op == OB) ? int'(br) : ((op == OJ) || (op == OJR)) ? 1 : 0);
            e_rw  = ((op == OS) || (op == OB)) ? 0 : 1;
            e_req = wf + 1 + (ldst ? wm + 1 : 0);
            e_mwr = (op == OS) ? wm + 1 : 0;
            chk($sformatf("rand%0d_op%h_retire", n, op), rc, e_rc);
            chk($sformatf("rand%0d_op%h_pcwrite", n, op), c_pcw, e_pcw);
            chk($sformatf("rand%0d_op%h_regwrite", n, op), c_rw, e_rw);
            chk($sformatf("rand%0d_op%h_memreq", n, op), c_req, e_req);
            chk($sformatf("rand%0d_op%h_memwrite", n, op), c_mwr, e_mwr);
            chk($sformatf("rand%0d_op%h_irwrite_fault", n, op), {c_irw[7:0], 7'd0, flt_seen}, {8'd1, 8'd0});
            if (rc == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core. It sequences the PC, IR, ALU operand muxes, register file write-back and one shared instruction/data memory port, one instruction at a time.
- The immediate is always taken from the immediate generator output (Imm), which decodes IR[6:0] itself. This block only steers Imm into the ALU.
- Sits between the IR/ALU flags and every datapath enable.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles MemReq may stay high without MemReady before a bus fault (legal range 2..255).

Ports:
- clk  in  1  system clock. One clock; reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset.
- Opcode  in  7  IR[6:0].
- Funct3  in  3  IR[14:12]. Forwarded to the ALU decoder; not used by the FSM.
- BrTaken  in  1  ALU branch-compare result, valid in EXEC.
- MemReady  in  1  memory completes the current request this cycle.
- MemReq  out  1  memory request.
- MemWrite  out  1  store. Valid only with MemReq.
- IorD  out  1  address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load IR and latch OldPC <= PC.
- PCWrite  out  1  PC update.
- PCSrc  out  2  next-PC select: 0 = ALU result, 1 = ALUOut, 2 = ALU result & ~1.
- ALUSrcA  out  2  operand A: 0 = PC, 1 = OldPC, 2 = rs1, 3 = zero.
- ALUSrcB  out  2  operand B: 0 = rs2, 1 = constant 4, 2 = Imm.
- ALUOp  out  2  0 = add, 1 = branch compare, 2 = funct decode.
- RegWrite  out  1  register file write.
- WBSel  out  2  write-back source: 0 = ALUOut, 1 = MDR, 2 = PC.
- Retire  out  1  one-cycle pulse per completed instruction.
- Fault  out  1  sticky: illegal opcode or memory timeout.
- State  out  3  current state, for debug.

Behaviour:

States:
- FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5.

Reset:
- While rst_n=0, all control outputs are forced to 0.
- On the clock edge with rst_n=0: state <= FETCH, Fault <= 0, wait counter <= 0.
- Reset takes effect from any state, including mid-MEM or FAULT. Any pending request is abandoned.

Outputs:
- Moore-decoded from state and Opcode.
- MemReady additionally gates PCWrite and IRWrite in FETCH, and the transitions out of FETCH and MEM.

Memory handshake:
- MemReq rises on entry to FETCH or MEM.
- MemReq, IorD and MemWrite are held stable until a cycle with MemReady=1. That cycle completes the transfer.
- The request is never withdrawn early. MemReady outside a request is ignored.

FETCH:
- Drive MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0.
- On MemReady: IRWrite=1, PCWrite=1, PCSrc=0 (PC <= PC+4), go to DECODE.

DECODE:
- Compute OldPC+Imm into ALUOut (ALUSrcA=1, ALUSrcB=2, ALUOp=0).
- Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111. These go to EXEC.
- Any other opcode goes to FAULT.

EXEC, per opcode class:
- R/I-ALU: ALUSrcA=2, ALUSrcB=0 (R) or 2 (I), ALUOp=2. Go to WB.
- Load/store: ALUSrcA=2, ALUSrcB=2, ALUOp=0. Go to MEM.
- Branch: ALUSrcA=2, ALUSrcB=0, ALUOp=1. PCWrite=BrTaken with PCSrc=1. Retire. Go to FETCH.
- JAL: PCWrite=1, PCSrc=1, RegWrite=1, WBSel=2. The register write uses pre-update PC (old+4). Retire. Go to FETCH.
- JALR: ALUSrcA=2, ALUSrcB=2, ALUOp=0, PCWrite=1, PCSrc=2, RegWrite=1, WBSel=2. Retire. Go to FETCH.
- LUI: ALUSrcA=3, ALUSrcB=2, ALUOp=0. Go to WB.

MEM:
- Drive MemReq=1, IorD=1, MemWrite=(store).
- On MemReady, load: go to WB. The datapath latches MDR.
- On MemReady, store: Retire. Go to FETCH.

WB:
- RegWrite=1, WBSel=1 (load) or 0 (other). Retire. Go to FETCH.

FAULT:
- All enables 0, Fault=1. Remains here until reset.

Wait timer:
- Counts cycles with MemReq=1 and MemReady=0. Cleared on every MemReady and on entry to FETCH/MEM.
- When the count reaches MEM_TIMEOUT-1 and MemReady=0 that cycle, go to FAULT next edge.
- MemReady on the final cycle wins over the timeout.

Latency with zero-wait memory, retire cycle counted from FETCH = cycle 1:
- Branch, JAL, JALR: 3.
- ALU, LUI, store: 4.
- Load: 5.
- Each memory wait cycle adds 1.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants;
  - state encoding;
  - PCSrc, ALUSrcA, ALUSrcB, ALUOp and WBSel encodings.
- One sub-module, mem_wait_timer:
  - parameter MEM_TIMEOUT;
  - ports clk, rst_n, clear, busy, timeout;
  - counter width $clog2(MEM_TIMEOUT).

Test Plan:
- Reset: rst_n=0 for 2 cycles, MemReady=1. Expect all enables 0, State=0, Fault=0. After release, MemReq=1 in the first cycle.
- ADDI 0x00500093, MemReady=1: cycles 1-4 show State=0,1,2,4. Expect RegWrite=1, WBSel=0 and Retire in cycle 4; PCWrite only in cycle 1.
- LW 0x0000A103, MemReady low for 3 cycles in MEM: MemReq/IorD=1 held 4 cycles, then WB with WBSel=1. Expect Retire in cycle 8.
- BEQ: with BrTaken=1, expect PCWrite=1, PCSrc=1 in cycle 3. With BrTaken=0, expect PCWrite=0. Both retire in cycle 3.
- Timeout, MEM_TIMEOUT=16, MemReady stuck 0 in FETCH: MemReq high 16 cycles, then State=5, Fault=1. A MemReady pulse on cycle 16 instead gives a normal DECODE.
- Opcode 0x7F: expect FAULT after DECODE, all enables 0. Assert rst_n=0 mid-MEM of a store: no MemWrite after the reset edge, State=FETCH.
